// File: rtl/mult_div_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : mult_div_ctrl_if
//  Brief  : EX-stage <-> multiply/divide controller handshake bundle.
//  Rev    : 1.0  initial release
// ============================================================================

`ifndef FUNCT_BUS
`define FUNCT_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef DOUBLE_DATA_BUS
`define DOUBLE_DATA_BUS 63:0
`endif
`ifndef FUNCT_MULT
`define FUNCT_MULT  6'h18
`endif
`ifndef FUNCT_MULTU
`define FUNCT_MULTU 6'h19
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV   6'h1A
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU  6'h1B
`endif

interface mult_div_ctrl_if;
  logic [`FUNCT_BUS]       funct;
  logic [`DATA_BUS]        operand_1;
  logic [`DATA_BUS]        operand_2;
  logic                    flush;
  logic                    stall_hold;
  logic                    mult_div_done;
  logic [`DOUBLE_DATA_BUS] mult_div_result;
  logic                    busy;

  modport master (
    output funct, operand_1, operand_2, flush, stall_hold,
    input  mult_div_done, mult_div_result, busy
  );

  modport slave (
    input  funct, operand_1, operand_2, flush, stall_hold,
    output mult_div_done, mult_div_result, busy
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : mult_div_ctrl
//  Brief  : Single-cycle multiply / iterative restoring divide for the EX stage.
//  Rev    : 1.0  initial release
// ============================================================================

`ifndef FUNCT_BUS
`define FUNCT_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef DOUBLE_DATA_BUS
`define DOUBLE_DATA_BUS 63:0
`endif
`ifndef FUNCT_MULT
`define FUNCT_MULT  6'h18
`endif
`ifndef FUNCT_MULTU
`define FUNCT_MULTU 6'h19
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV   6'h1A
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU  6'h1B
`endif

module mult_div_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_div_ctrl_if.slave md_if
);

  localparam int              CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state_q,  state_d;
  logic [`DATA_BUS]        op_a_q,   op_a_d;
  logic [`DATA_BUS]        op_b_q,   op_b_d;
  logic                    signed_q, signed_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [`DATA_BUS]        rem_q,    rem_d;
  logic [`DATA_BUS]        quo_q,    quo_d;
  logic [`DOUBLE_DATA_BUS] result_q, result_d;

  logic             w_in_div;
  logic             w_in_mul;
  logic             w_in_signed;
  logic             w_start;
  logic [`DATA_BUS] w_in_a_mag;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [`DATA_BUS] w_b_mag;
  logic             w_div_by_zero;
  logic             w_last_iter;

  logic [32:0]      w_shift;
  logic             w_ge;
  logic [`DATA_BUS] w_diff;
  logic [`DATA_BUS] w_rem_step;
  logic [`DATA_BUS] w_quo_step;
  logic [`DATA_BUS] w_rem_fix;
  logic [`DATA_BUS] w_quo_fix;

  logic [63:0]      w_mul_a;
  logic [63:0]      w_mul_b;
  logic [63:0]      w_prod;

  // Instruction decode and operand magnitude for the divider load.
  assign w_in_mul    = (md_if.funct == `FUNCT_MULT) || (md_if.funct == `FUNCT_MULTU);
  assign w_in_div    = (md_if.funct == `FUNCT_DIV)  || (md_if.funct == `FUNCT_DIVU);
  assign w_in_signed = (md_if.funct == `FUNCT_MULT) || (md_if.funct == `FUNCT_DIV);
  assign w_start     = (w_in_mul || w_in_div) && !md_if.flush;
  assign w_in_a_mag  = (w_in_signed && md_if.operand_1[31]) ? (~md_if.operand_1 + 32'd1)
                                                            : md_if.operand_1;

  assign w_a_neg       = signed_q && op_a_q[31];
  assign w_b_neg       = signed_q && op_b_q[31];
  assign w_b_mag       = w_b_neg ? (~op_b_q + 32'd1) : op_b_q;
  assign w_div_by_zero = (op_b_q == 32'd0);
  assign w_last_iter   = (cnt_q == CNT_LAST);

  // One restoring step: the true difference is below 2^32 whenever w_ge holds.
  assign w_shift    = {rem_q, quo_q[31]};
  assign w_ge       = (w_shift >= {1'b0, w_b_mag});
  assign w_diff     = w_shift[31:0] - w_b_mag;
  assign w_rem_step = w_ge ? w_diff : w_shift[31:0];
  assign w_quo_step = {quo_q[30:0], w_ge};

  assign w_quo_fix = (signed_q && (op_a_q[31] ^ op_b_q[31])) ? (~w_quo_step + 32'd1) : w_quo_step;
  assign w_rem_fix = w_a_neg ? (~w_rem_step + 32'd1) : w_rem_step;

  // Low 64 bits of the sign-extended product are exact for both signednesses.
  assign w_mul_a = {{32{w_a_neg}}, op_a_q};
  assign w_mul_b = {{32{w_b_neg}}, op_b_q};
  assign w_prod  = w_mul_a * w_mul_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d = w_in_div ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        state_d = S_DONE;
      end
      S_DIV: begin
        if (w_div_by_zero || w_last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!md_if.stall_hold) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (md_if.flush) begin
      state_d = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    md_if.mult_div_done   = (state_q == S_DONE);
    md_if.busy            = (state_q == S_MUL) || (state_q == S_DIV);
    md_if.mult_div_result = result_q;
  end

  // Datapath next-state
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          op_a_d   = md_if.operand_1;
          op_b_d   = md_if.operand_2;
          signed_d = w_in_signed;
          cnt_d    = '0;
          rem_d    = 32'd0;
          quo_d    = w_in_a_mag;
        end
      end
      S_MUL: begin
        if (!md_if.flush) begin
          result_d = w_prod;
        end
      end
      S_DIV: begin
        if (!md_if.flush) begin
          if (w_div_by_zero) begin
            result_d = {op_a_q, 32'hFFFF_FFFF};
          end else begin
            rem_d = w_rem_step;
            quo_d = w_quo_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last_iter) begin
              result_d = {w_rem_fix, w_quo_fix};
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      result_q <= 64'd0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : tb_mult_div_ctrl
//  Brief  : Directed self-checking bench for mult_div_ctrl.
//  Rev    : 1.0  initial release
// ============================================================================

module tb_mult_div_ctrl;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_NOP   = 6'h20;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   seen;

  mult_div_ctrl_if u_if ();

  mult_div_ctrl #(.DIV_CYCLES(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_if (u_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction for one edge, then scramble the inputs.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    u_if.funct     = f;
    u_if.operand_1 = a;
    u_if.operand_2 = b;
    step();
    u_if.funct     = F_NOP;
    u_if.operand_1 = ~a;
    u_if.operand_2 = 32'h5A5A_A5A5;
  endtask

  // Edges since the start edge until done is seen (bounded).
  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (u_if.mult_div_done !== 1'b1 && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    u_if.funct      = F_NOP;
    u_if.operand_1  = 32'd0;
    u_if.operand_2  = 32'd0;
    u_if.flush      = 1'b0;
    u_if.stall_hold = 1'b0;
    rst_n           = 1'b0;
    step();
    step();
    chk("rst_done",   {63'd0, u_if.mult_div_done}, 64'd0);
    chk("rst_busy",   {63'd0, u_if.busy},          64'd0);
    chk("rst_result", u_if.mult_div_result,        64'd0);
    rst_n = 1'b1;
    step();

    // MULT -3 * 7
    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy", {63'd0, u_if.busy}, 64'd1);
    wait_done(10, n);
    chk("mult_latency", 64'(n), 64'd2);
    chk("mult_result", u_if.mult_div_result, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    chk("mult_done_clear", {63'd0, u_if.mult_div_done}, 64'd0);

    // DIVU 100 / 7
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done(60, n);
    chk("divu_latency", 64'(n), 64'd33);
    chk("divu_result", u_if.mult_div_result, {32'd2, 32'd14});
    step();

    // DIV -7 / 2
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(60, n);
    chk("div_neg_latency", 64'(n), 64'd33);
    chk("div_neg_result", u_if.mult_div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    step();

    // DIV by zero
    issue(F_DIV, 32'h1234_5678, 32'd0);
    wait_done(60, n);
    chk("div0_latency", 64'(n), 64'd2);
    chk("div0_result", u_if.mult_div_result, {32'h1234_5678, 32'hFFFF_FFFF});
    step();

    // DIV overflow 0x80000000 / -1
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60, n);
    chk("div_ovf_result", u_if.mult_div_result, {32'd0, 32'h8000_0000});
    step();

    // MULTU with 3 stall cycles in DONE, then back-to-back MULTU
    issue(F_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(10, n);
    chk("multu_result", u_if.mult_div_result, 64'h0000_0001_0000_0000);
    u_if.stall_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_done",   {63'd0, u_if.mult_div_done}, 64'd1);
      chk("stall_result", u_if.mult_div_result, 64'h0000_0001_0000_0000);
    end
    u_if.stall_hold = 1'b0;
    u_if.funct      = F_MULTU;
    u_if.operand_1  = 32'hFFFF_FFFF;
    u_if.operand_2  = 32'hFFFF_FFFF;
    step();
    chk("b2b_idle_done", {63'd0, u_if.mult_div_done}, 64'd0);
    chk("b2b_idle_busy", {63'd0, u_if.busy},          64'd0);
    step();
    chk("b2b_start_busy", {63'd0, u_if.busy}, 64'd1);
    u_if.funct = F_NOP;
    step();
    chk("b2b_done",   {63'd0, u_if.mult_div_done}, 64'd1);
    chk("b2b_result", u_if.mult_div_result, 64'hFFFF_FFFE_0000_0001);
    step();

    // Flush at divide iteration 10
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (10) step();
    u_if.flush = 1'b1;
    step();
    u_if.flush = 1'b0;
    chk("flush_busy", {63'd0, u_if.busy},          64'd0);
    chk("flush_done", {63'd0, u_if.mult_div_done}, 64'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (u_if.mult_div_done === 1'b1) seen++;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_result", u_if.mult_div_result, 64'hFFFF_FFFE_0000_0001);

    // Asynchronous reset at divide iteration 20
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_done",   {63'd0, u_if.mult_div_done}, 64'd0);
    chk("arst_busy",   {63'd0, u_if.busy},          64'd0);
    chk("arst_result", u_if.mult_div_result,        64'd0);
    step();
    rst_n = 1'b1;
    #2;

    // Fresh operation after reset release
    issue(F_MULT, 32'd6, 32'd7);
    wait_done(10, n);
    chk("post_rst_latency", 64'(n), 64'd2);
    chk("post_rst_result", u_if.mult_div_result, 64'd42);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
